// File: rtl/ysyx_22040365_mcore.sv
// Multi-cycle RV64I-subset core: IDLE -> FETCH -> EXEC -> WB, with sticky HALT.
// Supports ADDI/ADD/SUB/LUI/AUIPC/JAL/EBREAK; anything else halts with illegal set.
module ysyx_22040365_mcore #(
    parameter int              XLEN     = 64,
    parameter int              RF_AW    = 5,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] out,
    output logic            wb_valid,
    output logic            halt,
    output logic            illegal
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [31:0] EBREAK_W = 32'h0010_0073;
    localparam int NREG = 1 << RF_AW;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] npc_q, npc_d;
    logic [XLEN-1:0] out_q, res_d;
    logic [31:0]     ir_q;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [RF_AW-1:0] rd_idx, rs1_idx, rs2_idx;
    logic             rd_ok, rs1_ok, rs2_ok;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic [XLEN-1:0]  imm_i, imm_u, imm_j, pc_seq, jal_tgt;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign rd_idx  = ir_q[7 +: RF_AW];
    assign rs1_idx = ir_q[15 +: RF_AW];
    assign rs2_idx = ir_q[20 +: RF_AW];

    // A register field is only legal if it fits in the configured file size.
    assign rd_ok  = (ir_q[11:7]  >> RF_AW) == 5'd0;
    assign rs1_ok = (ir_q[19:15] >> RF_AW) == 5'd0;
    assign rs2_ok = (ir_q[24:20] >> RF_AW) == 5'd0;

    assign rs1_val = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

    assign imm_i   = XLEN'($signed(ir_q[31:20]));
    assign imm_u   = XLEN'($signed({ir_q[31:12], 12'h000}));
    assign imm_j   = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));
    assign pc_seq  = pc_q + XLEN'(4);
    assign jal_tgt = pc_q + imm_j;

    always_comb begin
        state_d   = state_q;
        npc_d     = npc_q;
        res_d     = out_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (inst_valid) state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_WB;
                npc_d   = pc_seq;
                if (ir_q == EBREAK_W) begin
                    state_d = S_HALT;
                end else if (opcode == OP_IMM && funct3 == 3'b000 && rd_ok && rs1_ok) begin
                    res_d = rs1_val + imm_i;
                end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'b0000000
                             && rd_ok && rs1_ok && rs2_ok) begin
                    res_d = rs1_val + rs2_val;
                end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'b0100000
                             && rd_ok && rs1_ok && rs2_ok) begin
                    res_d = rs1_val - rs2_val;
                end else if (opcode == OP_LUI && rd_ok) begin
                    res_d = imm_u;
                end else if (opcode == OP_AUI && rd_ok) begin
                    res_d = pc_q + imm_u;
                end else if (opcode == OP_JAL && rd_ok && jal_tgt[1:0] == 2'b00) begin
                    res_d = pc_seq;
                    npc_d = jal_tgt;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // out_q only moves on EXEC->WB because res_d defaults to its current value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            npc_q     <= RESET_PC;
            ir_q      <= '0;
            out_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            npc_q     <= npc_d;
            out_q     <= res_d;
            illegal_q <= illegal_d;
            if (state_q == S_FETCH && inst_valid) ir_q <= inst;
            if (state_q == S_WB) pc_q <= npc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (state_q == S_WB && rd_idx != '0) begin
            rf_q[rd_idx] <= out_q;
        end
    end

    assign inst_req  = (state_q == S_FETCH);
    assign inst_addr = pc_q;
    assign out       = out_q;
    assign wb_valid  = (state_q == S_WB);
    assign halt      = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ysyx_22040365_mcore.sv
// Bench for ysyx_22040365_mcore: directed scenarios plus random instruction streams
// checked against an instruction-level model of the core.
`timescale 1ns/1ps
module tb_ysyx_22040365_mcore;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, inst_valid, inst_req, wb_valid, halt, illegal;
    logic [31:0] inst;
    logic [63:0] inst_addr, out;

    logic        rst4, iv4, req4, wb4, halt4, ill4;
    logic [31:0] inst4;
    logic [63:0] addr4, out4;

    ysyx_22040365_mcore u_dut (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_valid(inst_valid), .inst(inst), .out(out), .wb_valid(wb_valid),
        .halt(halt), .illegal(illegal)
    );

    ysyx_22040365_mcore #(.RF_AW(4)) u_dut4 (
        .clk(clk), .rst(rst4), .inst_req(req4), .inst_addr(addr4),
        .inst_valid(iv4), .inst(inst4), .out(out4), .wb_valid(wb4),
        .halt(halt4), .illegal(ill4)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Instruction-level model: architectural registers, pc and sticky status.
    logic [63:0] m_rf [32];
    logic [63:0] m_pc, m_out;
    logic        m_wb, m_halt, m_ill;

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        m_pc = RPC; m_out = 64'd0; m_wb = 1'b0; m_halt = 1'b0; m_ill = 1'b0;
    endtask

    task automatic mdl_exec(input logic [31:0] w);
        logic [63:0] ii, iu, ij, a, b, val, nxt, tgt;
        ii  = 64'($signed(w[31:20]));
        iu  = 64'($signed({w[31:12], 12'h000}));
        ij  = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        a   = m_rf[w[19:15]];
        b   = m_rf[w[24:20]];
        nxt = m_pc + 64'd4;
        val = 64'd0;
        m_wb = 1'b1; m_ill = 1'b0;
        if (w == 32'h0010_0073) begin
            m_wb = 1'b0; m_halt = 1'b1;
        end else begin
            case (w[6:0])
                7'h13: if (w[14:12] == 3'd0) val = a + ii; else m_ill = 1'b1;
                7'h33: if (w[14:12] == 3'd0 && w[31:25] == 7'h00) val = a + b;
                       else if (w[14:12] == 3'd0 && w[31:25] == 7'h20) val = a - b;
                       else m_ill = 1'b1;
                7'h37: val = iu;
                7'h17: val = m_pc + iu;
                7'h6f: begin
                    tgt = m_pc + ij;
                    if (tgt[1:0] != 2'b00) m_ill = 1'b1;
                    else begin val = m_pc + 64'd4; nxt = tgt; end
                end
                default: m_ill = 1'b1;
            endcase
            if (m_ill) begin m_wb = 1'b0; m_halt = 1'b1; end
        end
        if (m_wb) begin
            if (w[11:7] != 5'd0) m_rf[w[11:7]] = val;
            m_out = val;
            m_pc  = nxt;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mdl_reset();
    endtask

    // Issues one instruction from a FETCH cycle, stalling dly cycles first.
    task automatic run_inst(input logic [31:0] w, input int dly);
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== m_pc) begin
            n_err++;
            $display("FAIL fetch_req: req=%b addr=%h, want req=1 addr=%h", inst_req, inst_addr, m_pc);
        end
        for (int k = 0; k < dly; k++) begin
            inst_valid = 1'b0; inst = $urandom;
            @(negedge clk);
            n_cmp++;
            if (inst_req !== 1'b1 || inst_addr !== m_pc || wb_valid !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_stall: req=%b addr=%h wb=%b, want 1 %h 0", inst_req, inst_addr, wb_valid, m_pc);
            end
        end
        inst_valid = 1'b1; inst = w;
        @(negedge clk);
        inst_valid = 1'($urandom_range(0, 1)); inst = $urandom;
        n_cmp++;
        if (inst_req !== 1'b0 || wb_valid !== 1'b0 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL exec_cycle: req=%b wb=%b halt=%b, want 0 0 0", inst_req, wb_valid, halt);
        end
        @(negedge clk);
        inst_valid = 1'b0;
        mdl_exec(w);
        n_cmp++;
        if (wb_valid !== m_wb || halt !== m_halt || illegal !== m_ill || out !== m_out) begin
            n_err++;
            $display("FAIL retire %h: wb=%b halt=%b ill=%b out=%h, want %b %b %b %h",
                     w, wb_valid, halt, illegal, out, m_wb, m_halt, m_ill, m_out);
        end
        if (!m_halt) begin
            @(negedge clk);
            n_cmp++;
            if (wb_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== m_pc) begin
                n_err++;
                $display("FAIL next_fetch: wb=%b req=%b addr=%h, want 0 1 %h", wb_valid, inst_req, inst_addr, m_pc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; inst_valid = 1'b0; inst = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (inst_req !== 1'b0 || inst_addr !== RPC || out !== 64'd0 || wb_valid !== 1'b0
            || halt !== 1'b0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: req=%b addr=%h out=%h wb=%b halt=%b ill=%b", inst_req, inst_addr, out, wb_valid, halt, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (inst_req !== 1'b0) begin
            n_err++; $display("FAIL idle_no_req: req=%b want 0", inst_req);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== RPC) begin
            n_err++; $display("FAIL first_req: req=%b addr=%h want 1 %h", inst_req, inst_addr, RPC);
        end
        mdl_reset();
    endtask

    task automatic test_addi();
        run_inst(32'h0050_0093, 0);
        n_cmp++;
        if (out !== 64'd5 || inst_addr !== 64'h8000_0004) begin
            n_err++; $display("FAIL addi_first: out=%h addr=%h want 5 80000004", out, inst_addr);
        end
    endtask

    task automatic test_add_sub();
        run_inst(32'hfff0_0093, 0);
        n_cmp++;
        if (out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL addi_neg: out=%h want ffffffffffffffff", out); end
        run_inst(32'h0010_8133, 1);
        n_cmp++;
        if (out !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL add_reg: out=%h want fffffffffffffffe", out); end
        run_inst(32'h4010_01b3, 0);
        n_cmp++;
        if (out !== 64'd1) begin n_err++; $display("FAIL sub_reg: out=%h want 1", out); end
    endtask

    task automatic test_x0();
        run_inst(32'h0070_0013, 0);
        n_cmp++;
        if (out !== 64'd7) begin n_err++; $display("FAIL x0_write_out: out=%h want 7", out); end
        run_inst(32'h0000_00b3, 0);
        n_cmp++;
        if (out !== 64'd0) begin n_err++; $display("FAIL x0_reads_zero: out=%h want 0", out); end
    endtask

    task automatic test_fetch_stall_jal();
        do_reset();
        run_inst(32'h0080_00ef, 4);
        n_cmp++;
        if (out !== 64'h8000_0004 || inst_addr !== 64'h8000_0008) begin
            n_err++; $display("FAIL jal: out=%h addr=%h want 80000004 80000008", out, inst_addr);
        end
    endtask

    task automatic test_ebreak();
        run_inst(32'h0010_0073, 0);
        for (int k = 0; k < 6; k++) begin
            inst_valid = 1'b1; inst = 32'h0050_0093;
            @(negedge clk);
            n_cmp++;
            if (halt !== 1'b1 || illegal !== 1'b0 || inst_req !== 1'b0 || wb_valid !== 1'b0) begin
                n_err++; $display("FAIL ebreak_hold: halt=%b ill=%b req=%b wb=%b want 1 0 0 0", halt, illegal, inst_req, wb_valid);
            end
        end
        inst_valid = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        run_inst(32'hFFFF_FFFF, 0);
        n_cmp++;
        if (halt !== 1'b1 || illegal !== 1'b1 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL illegal_ones: halt=%b ill=%b wb=%b want 1 1 0", halt, illegal, wb_valid);
        end
        do_reset();
        run_inst(32'h2000_0033, 0);   // add with bad funct7
        do_reset();
        run_inst(32'h0050_0093, 0);
        run_inst(32'h0020_00ef, 0);   // jal target off by 2
        n_cmp++;
        if (illegal !== 1'b1 || out !== 64'd5) begin
            n_err++; $display("FAIL jal_misaligned: ill=%b out=%h want 1 5", illegal, out);
        end
    endtask

    task automatic test_rf_aw4();
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        iv4 = 1'b1; inst4 = 32'h00F0_0793;   // addi x15,x0,15
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wb4 !== 1'b1 || out4 !== 64'd15) begin n_err++; $display("FAIL aw4_x15: wb=%b out=%h want 1 f", wb4, out4); end
        @(negedge clk);
        iv4 = 1'b1; inst4 = 32'h0100_0893;   // addi x17,x0,16
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (halt4 !== 1'b1 || ill4 !== 1'b1 || wb4 !== 1'b0 || out4 !== 64'd15) begin
            n_err++; $display("FAIL aw4_x17: halt=%b ill=%b wb=%b out=%h want 1 1 0 f", halt4, ill4, wb4, out4);
        end
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        run_inst(32'h0090_0093, 0);
        inst_valid = 1'b1; inst = 32'h0050_8093;   // addi x1,x1,5
        @(negedge clk);
        inst_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (inst_req !== 1'b0 || inst_addr !== RPC || out !== 64'd0 || wb_valid !== 1'b0
            || halt !== 1'b0 || illegal !== 1'b0) begin
            n_err++; $display("FAIL reset_exec_async: req=%b addr=%h out=%h wb=%b halt=%b ill=%b", inst_req, inst_addr, out, wb_valid, halt, illegal);
        end
        @(negedge clk);
        n_cmp++;
        if (wb_valid !== 1'b0 || out !== 64'd0) begin
            n_err++; $display("FAIL reset_exec_nowb: wb=%b out=%h want 0 0", wb_valid, out);
        end
        rst = 1'b0;
        mdl_reset();
        @(negedge clk);
        run_inst(32'h0000_8133, 0);   // add x2,x1,x0
    endtask

    task automatic test_random();
        logic [31:0] w, r;
        logic [4:0]  rd, rs1, rs2;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            r = $urandom; rd = 5'($urandom); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1, 9: w = {r[11:0], rs1, 3'b000, rd, 7'h13};
                2:       w = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
                3:       w = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
                4:       w = {r[19:0], rd, 7'h37};
                5:       w = {r[19:0], rd, 7'h17};
                6: begin
                    w = {r[19:0], rd, 7'h6f};
                    if (r[31:30] != 2'b00) w[21] = 1'b0;
                end
                default: w = r;
            endcase
            run_inst(w, $urandom_range(0, 2));
            if (m_halt) do_reset();
        end
    endtask

    initial begin
        rst4 = 1'b1; iv4 = 1'b0; inst4 = 32'd0;
        test_reset();
        test_addi();
        test_add_sub();
        test_x0();
        test_fetch_stall_jal();
        test_ebreak();
        test_illegal();
        test_rf_aw4();
        test_reset_in_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
